fila_param: RTL

- Parametrised successor to the 8x8 shift queue: circular-buffer FIFO with configurable data width and depth.
- Adds full/empty/almost-full flags, error pulses, a registered read-data valid strobe, and single-cycle simultaneous enqueue+dequeue.
- Occupancy output is exact in the cycle after every operation.
- Sits between the input capture logic and the display/consumer logic, in the same clock domain as the existing queue.

---
 rtl/fila_pkg.sv | 15 +
 rtl/fila_mem.sv | 40 ++++
 rtl/fila_param.sv | 108 ++++++++++
 3 files changed

// File: rtl/fila_pkg.sv
// Shared definitions for the fila_param circular-buffer FIFO.
// Contents:
//   DEFAULT_WIDTH, DEFAULT_DEPTH : default word width and entry count
//   next_ptr(ptr, depth)         : pointer increment with wrap from depth-1 to 0
package fila_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 8;

  // Explicit compare-and-wrap, so DEPTH does not have to be a power of two.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fila_mem.sv
// DEPTH x WIDTH storage array for fila_param.
// Ports:
//   clk   : clock, rising edge
//   clr   : synchronous clear of the registered read data (has priority over re)
//   we    : write enable; waddr/wdata give the slot and word
//   re    : read enable; rdata <= mem[raddr] on the edge
//   rdata : registered read data, held between reads
// A read and a write to the same slot on one edge return the old contents.
module fila_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fila_param.sv
// Parametrised circular-buffer FIFO with occupancy, flags and error pulses.
// Ports:
//   clk_10KHz       : sole clock, rising edge
//   reset           : synchronous active-low reset
//   data_in         : word to enqueue
//   enqueue_in      : enqueue request (level, sampled each cycle)
//   dequeue_in      : dequeue request (level, sampled each cycle)
//   data_out        : last dequeued word, registered, held between dequeues
//   valid_out       : one-cycle pulse when data_out was updated
//   len_out         : occupancy 0..DEPTH
//   full_out        : len_out == DEPTH
//   empty_out       : len_out == 0
//   almost_full_out : len_out >= AF_LEVEL
//   overflow_out    : one-cycle pulse, an enqueue was rejected
//   underflow_out   : one-cycle pulse, a dequeue was rejected
module fila_param
  import fila_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic             clk_10KHz,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enqueue_in,
  input  logic             dequeue_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [CW-1:0]    len_out,
  output logic             full_out,
  output logic             empty_out,
  output logic             almost_full_out,
  output logic             overflow_out,
  output logic             underflow_out
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic          deq_ok;
  logic          enq_ok;

  // Acceptance uses the pre-edge count; a full queue still takes a write
  // when a read frees the slot on the same edge. No fall-through when empty.
  always_comb begin
    deq_ok    = dequeue_in && (count != '0);
    enq_ok    = enqueue_in && ((count != CW'(DEPTH)) || deq_ok);
    count_nxt = count;
    if (enq_ok && !deq_ok) begin
      count_nxt = count + 1'b1;
    end else if (deq_ok && !enq_ok) begin
      count_nxt = count - 1'b1;
    end
  end

  fila_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_mem (
    .clk   (clk_10KHz),
    .clr   (!reset),
    .we    (enq_ok && reset),
    .waddr (tail),
    .wdata (data_in),
    .re    (deq_ok),
    .raddr (head),
    .rdata (data_out)
  );

  // Flags are registered from count_nxt so they agree with len_out in the
  // cycle right after the operation.
  always_ff @(posedge clk_10KHz) begin
    if (!reset) begin
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      valid_out       <= 1'b0;
      len_out         <= '0;
      full_out        <= 1'b0;
      empty_out       <= 1'b1;
      almost_full_out <= 1'b0;
      overflow_out    <= 1'b0;
      underflow_out   <= 1'b0;
    end else begin
      if (enq_ok) begin
        tail <= PW'(next_ptr(32'(tail), DEPTH));
      end
      if (deq_ok) begin
        head <= PW'(next_ptr(32'(head), DEPTH));
      end
      count           <= count_nxt;
      valid_out       <= deq_ok;
      len_out         <= count_nxt;
      full_out        <= (count_nxt == CW'(DEPTH));
      empty_out       <= (count_nxt == '0);
      almost_full_out <= (count_nxt >= CW'(AF_LEVEL));
      overflow_out    <= enqueue_in && !enq_ok;
      underflow_out   <= dequeue_in && !deq_ok;
    end
  end

endmodule
